// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for a 5-stage pipeline with a memory-wait freeze, timeout and perf counters
module hazard_ctrl #(
  parameter int REG_LENGTH = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_WIDTH = 8,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_LENGTH-1:0] rs1_d,
  input  logic [REG_LENGTH-1:0] rs2_d,
  input  logic [REG_LENGTH-1:0] rs1_e,
  input  logic [REG_LENGTH-1:0] rs2_e,
  input  logic [REG_LENGTH-1:0] rd_e,
  input  logic [1:0]            result_src_e,
  input  logic                  pc_src_e,
  input  logic [REG_LENGTH-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_LENGTH-1:0] rd_w,
  input  logic                  reg_write_w,
  input  logic                  mem_busy,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  mem_timeout,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [WAIT_WIDTH-1:0] MAX_W = WAIT_WIDTH'(MAX_WAIT);
  state_t                state;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  lw_stall, m_a, m_b, w_a, w_b;
  always_comb begin
    lw_stall    = result_src_e == 2'b01 && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    m_a         = reg_write_m && rd_m != '0 && rd_m == rs1_e;
    m_b         = reg_write_m && rd_m != '0 && rd_m == rs2_e;
    w_a         = reg_write_w && rd_w != '0 && rd_w == rs1_e;
    w_b         = reg_write_w && rd_w != '0 && rd_w == rs2_e;
    // reset gates every output so nothing leaks out while rst is low
    stall_f     = rst && (mem_busy || (lw_stall && !pc_src_e));
    stall_d     = stall_f;
    stall_e     = rst && mem_busy;
    stall_m     = stall_e;
    flush_d     = rst && !mem_busy && pc_src_e;
    flush_e     = rst && !mem_busy && (lw_stall || pc_src_e);
    forward_a_e = !rst ? 2'b00 : m_a ? 2'b10 : w_a ? 2'b01 : 2'b00;
    forward_b_e = !rst ? 2'b00 : m_b ? 2'b10 : w_b ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (mem_busy) begin
        state    <= MEM_WAIT;
        wait_cnt <= state == RUN ? WAIT_WIDTH'(1) : wait_cnt == '1 ? wait_cnt : wait_cnt + WAIT_WIDTH'(1);
        if (wait_cnt == MAX_W) mem_timeout <= 1'b1;
      end else begin
        state    <= RUN;
        wait_cnt <= '0;
      end
      if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_e && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a per-cycle behavioural model and literal pins
module tb_hazard_ctrl;
  localparam int RL = 5, CW = 6, WW = 8, MW = 16;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst;
  logic [RL-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e, forward_a_e, forward_b_e;
  logic pc_src_e, reg_write_m, reg_write_w, mem_busy;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0, fails = 0;
  int m_stall = 0, m_flush = 0, busy_run = 0;
  bit m_to = 0;

  hazard_ctrl #(.REG_LENGTH(RL), .CNT_WIDTH(CW), .WAIT_WIDTH(WW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .result_src_e(result_src_e), .pc_src_e(pc_src_e), .rd_m(rd_m),
    .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w), .mem_busy(mem_busy),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  wire [10:0] outs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, forward_a_e, forward_b_e, mem_timeout};

  function automatic logic [1:0] fwd(input logic [RL-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] expect_outs();
    bit lw, sf, fd, fe;
    if (!rst) return 11'b0;
    lw = result_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    sf = mem_busy || (lw && !pc_src_e);
    fd = !mem_busy && pc_src_e;
    fe = !mem_busy && (lw || pc_src_e);
    return {sf, sf, mem_busy, mem_busy, fd, fe, fwd(rs1_e), fwd(rs2_e), m_to};
  endfunction

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_stall = 0; m_flush = 0; busy_run = 0; m_to = 0;
    end else begin
      logic [10:0] e;
      e = expect_outs();
      if (e[10] && m_stall < SAT) m_stall++;
      if (e[5] && m_flush < SAT) m_flush++;
      if (mem_busy && busy_run >= MW) m_to = 1;
      busy_run = mem_busy ? busy_run + 1 : 0;
    end
  end

  always @(negedge clk) begin
    ck("model_outs", outs, expect_outs());
    ck("model_cnts", {stall_cnt, flush_cnt}, {CW'(m_stall), CW'(m_flush)});
  end

  initial begin
    rst = 1;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {result_src_e, pc_src_e, reg_write_m, reg_write_w, mem_busy} = '0;
    #1 rst = 0;
    #1;
    ck("reset_outs", outs, 0);
    ck("reset_cnts", {stall_cnt, flush_cnt}, 0);
    cyc();
    rst = 1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    #1 ck("fwd_mem", forward_a_e, 2'b10);
    cyc();
    reg_write_m = 0;
    #1 ck("fwd_wb", forward_a_e, 2'b01);
    cyc();
    rd_m = 0; rd_w = 0;
    #1 ck("fwd_x0", forward_a_e, 2'b00);
    cyc();
    rs2_e = 3; rd_w = 3;
    #1 ck("fwd_b_wb", {forward_a_e, forward_b_e}, 4'b0001);
    cyc();
    {rs1_e, rs2_e, rd_w, reg_write_w} = '0;
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    #1 ck("lu_ctl", {stall_f, stall_d, flush_d, flush_e}, 4'b1101);
    cyc();
    ck("lu_cnt", {stall_cnt, flush_cnt}, {CW'(1), CW'(1)});
    pc_src_e = 1;
    #1 ck("br_lu_ctl", {stall_f, stall_d, flush_d, flush_e}, 4'b0011);
    cyc();
    ck("br_lu_cnt", {stall_cnt, flush_cnt}, {CW'(1), CW'(2)});
    pc_src_e = 0; rd_e = 0; rs2_d = 0;
    #1 ck("lu_x0", {stall_f, stall_d, flush_d, flush_e}, 4'b0000);
    cyc();
    result_src_e = 0;
    pc_src_e = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 ck("mw_frozen", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}, 6'b111100);
      cyc();
    end
    mem_busy = 0;
    #1 ck("mw_release", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}, 6'b000011);
    cyc();
    ck("mw_cnt", {stall_cnt, flush_cnt}, {CW'(4), CW'(3)});
    pc_src_e = 0; mem_busy = 1;
    repeat (15) cyc();
    ck("to_early", mem_timeout, 0);
    repeat (5) cyc();
    ck("to_set", mem_timeout, 1);
    mem_busy = 0;
    repeat (3) cyc();
    ck("to_sticky", {mem_timeout, stall_f, stall_cnt}, {1'b1, 1'b0, CW'(24)});
    mem_busy = 1;
    repeat (50) cyc();
    mem_busy = 0;
    #1 ck("stall_sat", stall_cnt, SAT);
    cyc();
    mem_busy = 1; pc_src_e = 1;
    repeat (5) cyc();
    #2 rst = 0;
    #1 ck("areset_outs", outs, 0);
    ck("areset_cnts", {stall_cnt, flush_cnt}, 0);
    @(posedge clk);
    #1 rst = 1; mem_busy = 0;
    #1 ck("post_reset_run", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}, 6'b000011);
    cyc();
    ck("post_reset_cnt", {mem_timeout, stall_cnt, flush_cnt}, {1'b0, CW'(0), CW'(1)});
    pc_src_e = 0;
    cyc();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
